uart_rx_parser: RTL and testbench
=================================

# uart_rx_parser

Receive-side counterpart of the distance UART transmitter. The block deserialises 8N1 bytes from the STM32 link on `UART_rx` and assembles ASCII decimal lines terminated by `"\n"` into a 19-bit binary value. It presents that value to the FPGA core with a one-cycle valid strobe, for example as a threshold or command value. The raw byte strobe and error strobes are exported for debug and status logic.

## Interface
- `CLK`, 50000000, clock frequency in Hz
- `BAUD`, 115200, baud rate
- `MAX_DIGITS`, 6, maximum digit characters accepted per line
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  synchronous, active-high reset
- `UART_rx`  in  1  serial input, asynchronous, idle high
- `rx_data`  out  8  last correctly framed byte
- `rx_valid`  out  1  one-cycle strobe; `rx_data` updated this cycle
- `frame_err`  out  1  one-cycle strobe; stop bit sampled low
- `value`  out  19  last successfully parsed line value
- `value_valid`  out  1  one-cycle strobe; `value` updated this cycle
- `parse_err`  out  1  one-cycle strobe; line rejected at its `"\n"`

## Operation
- Derived constants:
  - `BIT_CNT = CLK/BAUD`, integer division; the default gives 434.
  - `HALF = BIT_CNT/2`; the default gives 217.
- Synchroniser: `UART_rx` passes through a 2-flop synchroniser, then one further register is used for edge detection. Reset loads all three flops with 1.
- Receiver FSM states: `IDLE`, `START`, `DATA`, `STOP`, `WAIT_HIGH`.
  - `IDLE`: a falling edge on the synchronised line moves to `START` and clears the baud counter.
  - `START`: when the baud counter reaches `HALF-1`, sample the line.
    - Low: go to `DATA`, clear the counter and bit index.
    - High: treat as a glitch and return to `IDLE`.
  - `DATA`: every `BIT_CNT` cycles, sample one bit into the shift register, LSB first. After bit 7 go to `STOP`.
  - `STOP`: after `BIT_CNT` cycles, sample the line.
    - High: load `rx_data`, pulse `rx_valid`, go to `IDLE`.
    - Low: pulse `frame_err` and go to `WAIT_HIGH`. `rx_data` is unchanged and the byte is not passed to the parser.
  - `WAIT_HIGH`: return to `IDLE` once the synchronised line is high.
- Parser FSM states: `ACCUM`, `DISCARD`. It acts only in cycles where `rx_valid` is high. Registers: 20-bit accumulator, digit counter.
  - Digit `"0"`–`"9"` in `ACCUM`: `acc <= acc*10 + (byte - 8'h30)` and increment the digit count.
    - If the count would exceed `MAX_DIGITS`, go to `DISCARD` instead.
    - The `acc*10` product is computed 24 bits wide, so there is no intermediate truncation.
  - `"\r"` (8'h0D) and `" "` (8'h20) are ignored in both states.
  - Any other non-`"\n"` byte in `ACCUM`: go to `DISCARD`.
  - `"\n"` (8'h0A):
    - If the state is `ACCUM`, the count is at least 1 and `acc <= 20'h7FFFF`: load `value <= acc[18:0]` and pulse `value_valid`.
    - Otherwise pulse `parse_err`.
    - In either case clear `acc` and the count, and go to `ACCUM`.
  - Inside `DISCARD`, all bytes other than `"\n"` are dropped.
- `value_valid` and `parse_err` are never high in the same cycle.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `value`=0, `value_valid`=0, `parse_err`=0. Both FSMs return to their initial states (`IDLE`, `ACCUM`), and `acc` and the digit count are cleared. This applies to a reset asserted mid-frame or mid-line as well: the partial byte or line is discarded with no strobe.
- Data sampling point: bit *n* (n = 0..7) is sampled `HALF + (n+1)*BIT_CNT` cycles after the synchronised falling edge, ±1 cycle.
- `rx_valid` and `frame_err` are registered. They assert in the cycle after the stop-bit sample.
- `value_valid` and `parse_err` assert exactly 1 cycle after the `rx_valid` that carried `"\n"`.
- Any low pulse shorter than `HALF` cycles on the synchronised line produces no strobe.
- Back-to-back frames with zero idle gap are received without loss. `IDLE` re-arms in the cycle after the stop sample, which is before the next start edge.
- Latency from `UART_rx` pin to the synchroniser output is 2 cycles.
- `rx_valid` is never high for more than 1 cycle. At the default settings the minimum spacing between `rx_valid` strobes is 10×434 cycles.

## Test plan
- Send `"1234\n"` at 115200 baud → five `rx_valid` pulses with bytes 31,32,33,34,0A. Then `value_valid` 1 cycle after the last pulse, with `value`=1234.
- Send `"524287\r\n"` → `value`=19'h7FFFF with `value_valid`. Then send `"524288\n"` → `parse_err`; `value` remains 524287.
- Send `"12a4\n"`, then `"\n"`, then `"1234567\n"` → three `parse_err` pulses and no `value_valid`. Then send `"7\n"` → `value`=7.
- Send byte 8'h35 with the stop bit forced low → `frame_err`, no `rx_valid`, `rx_data` unchanged. Next send `"9\n"` → `value`=9, since the framed-bad byte never reached the parser.
- Drive a 100-cycle low glitch on `UART_rx` → no strobes. Then send 8'h41 back-to-back with 8'h0A, no idle gap → two correct `rx_valid` pulses and a `parse_err`.
- Assert `rst` for 1 cycle during bit 4 of a frame → all outputs 0 the next cycle. Then send `"42\n"` → `value`=42, with no spurious strobe from the aborted frame.

Source files
------------

// File: rtl/uart_rx_parser.sv
// 8N1 UART receiver feeding an ASCII-decimal line parser that yields a 19-bit value per "\n".
// rx_valid/frame_err one cycle after the stop sample, value_valid/parse_err one cycle after the "\n" byte; no backpressure.
module uart_rx_parser #(
   parameter int CLK        = 50000000,
   parameter int BAUD       = 115200,
   parameter int MAX_DIGITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        UART_rx,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        frame_err,
   output logic [18:0] value,
   output logic        value_valid,
   output logic        parse_err
);
   localparam int BIT_CNT = CLK / BAUD;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
   localparam int DCNT_W  = $clog2(MAX_DIGITS + 1);

   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(MAX_DIGITS);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   localparam logic P_ACCUM   = 1'b0;
   localparam logic P_DISCARD = 1'b1;

   logic              rx_s1;
   logic              rx_s2;
   logic              rx_d;
   logic [2:0]        rx_state;
   logic [CNT_W-1:0]  baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              p_state;
   logic [19:0]       acc;
   logic [DCNT_W-1:0] dcnt;
   logic              is_digit;
   logic              is_skip;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= UART_rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= S_IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               if (rx_d && !rx_s2) begin
                  rx_state <= S_START;
                  baud_cnt <= '0;
               end
            end
            S_START: begin
               // mid-start-bit check rejects glitches shorter than half a bit
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt <= '0;
                  shreg    <= {rx_s2, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     rx_state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt <= '0;
                  if (rx_s2) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                     rx_state <= S_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     rx_state  <= S_WAIT_HIGH;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            S_WAIT_HIGH: begin
               if (rx_s2) begin
                  rx_state <= S_IDLE;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_skip  = (rx_data == 8'h0D) || (rx_data == 8'h20);

   always_ff @(posedge clk) begin
      if (rst) begin
         p_state     <= P_ACCUM;
         acc         <= '0;
         dcnt        <= '0;
         value       <= '0;
         value_valid <= 1'b0;
         parse_err   <= 1'b0;
      end else begin
         value_valid <= 1'b0;
         parse_err   <= 1'b0;
         if (rx_valid) begin
            if (rx_data == 8'h0A) begin
               if (p_state == P_ACCUM && dcnt != '0 && acc <= 20'h7FFFF) begin
                  value       <= acc[18:0];
                  value_valid <= 1'b1;
               end else begin
                  parse_err <= 1'b1;
               end
               acc     <= '0;
               dcnt    <= '0;
               p_state <= P_ACCUM;
            end else if (!is_skip && p_state == P_ACCUM) begin
               if (!is_digit || dcnt == DCNT_MAX) begin
                  p_state <= P_DISCARD;
               end else begin
                  // product kept 24 bits wide before narrowing back to the accumulator
                  acc  <= 20'(({4'b0, acc} * 24'd10) + {20'b0, rx_data[3:0]});
                  dcnt <= dcnt + DCNT_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_parser.sv
// Directed bench for uart_rx_parser: serialises ASCII lines and checks bytes, strobes and parsed values
// against a line-level model (digits/ignore-set/length/range rules evaluated on whole lines).
module tb_uart_rx_parser;
   localparam int TB_CLK  = 6400000;
   localparam int TB_BAUD = 100000;
   localparam int BIT     = TB_CLK / TB_BAUD;
   localparam int HALF    = BIT / 2;
   localparam int MAXD    = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        UART_rx = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic [18:0] value;
   logic        value_valid;
   logic        parse_err;

   uart_rx_parser #(.CLK(TB_CLK), .BAUD(TB_BAUD), .MAX_DIGITS(MAXD)) dut (
      .clk(clk), .rst(rst), .UART_rx(UART_rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .value(value), .value_valid(value_valid), .parse_err(parse_err)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_rx[$];
   bit         exp_ok[$];
   int         exp_val[$];
   logic [7:0] line_buf[$];
   int exp_fe = 0;
   int n_rxv = 0, n_vv = 0, n_pe = 0, n_fe = 0;
   int n_checks = 0, n_pass = 0;
   int cur_value = 0;
   bit prev_nl = 0;
   bit ok_c;
   int v_c;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // line model: evaluate the whole line once its "\n" is sent
   task automatic model_byte(input logic [7:0] b);
      int     n;
      bit     bad;
      bit     ok;
      longint v;
      if (b != 8'h0A) begin
         line_buf.push_back(b);
         return;
      end
      n = 0; bad = 0; v = 0;
      foreach (line_buf[i]) begin
         if (line_buf[i] == 8'h0D || line_buf[i] == 8'h20) continue;
         if (line_buf[i] >= 8'h30 && line_buf[i] <= 8'h39) begin
            n++;
            v = v * 10 + longint'(line_buf[i] - 8'h30);
         end else begin
            bad = 1;
         end
      end
      ok = !bad && n >= 1 && n <= MAXD && v <= 524287;
      exp_ok.push_back(ok);
      exp_val.push_back(ok ? int'(v) : 0);
      line_buf.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      if (stop_ok) begin
         exp_rx.push_back(b);
         model_byte(b);
      end else begin
         exp_fe++;
      end
      UART_rx = 1'b0; tick(BIT);
      for (int i = 0; i < 8; i++) begin
         UART_rx = b[i]; tick(BIT);
      end
      UART_rx = stop_ok; tick(BIT);
      UART_rx = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i], 1'b1);
         tick(HALF);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_nl   = 0;
         cur_value = 0;
      end else begin
         if (rx_valid) begin
            n_rxv++;
            if (exp_rx.size() == 0) check("rx_valid_expected", 0, 1);
            else check("rx_data", rx_data, exp_rx.pop_front());
         end
         if (frame_err) begin
            n_fe++;
            check("frame_err_expected", exp_fe > 0, 1);
            if (exp_fe > 0) exp_fe--;
         end
         check("strobe_excl", value_valid & parse_err, 0);
         check("line_strobe_timing", value_valid | parse_err, prev_nl);
         if (value_valid | parse_err) begin
            if (value_valid) n_vv++; else n_pe++;
            if (exp_ok.size() == 0) begin
               check("line_event_expected", 0, 1);
            end else begin
               ok_c = exp_ok.pop_front();
               v_c  = exp_val.pop_front();
               check("line_ok", value_valid, ok_c);
               if (ok_c) begin
                  check("value", value, v_c);
                  cur_value = v_c;
               end
            end
         end
         check("value_hold", value, cur_value);
         prev_nl = rx_valid && rx_data == 8'h0A;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pb;
      tick(4);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rx_data", rx_data, 0);
      check("rst_value", value, 0);
      check("rst_strobes", {rx_valid, frame_err, value_valid, parse_err}, 0);
      tick(2);

      send_str("1234\n"); tick(BIT);
      check("t1_value", value, 1234);
      check("t1_rxv", n_rxv, 5);
      check("t1_vv", n_vv, 1);
      check("t1_rx_data", rx_data, 8'h0A);

      send_str("524287\r\n"); tick(BIT);
      check("t2_value_max", value, 19'h7FFFF);
      check("t2_vv", n_vv, 2);
      send_str("524288\n"); tick(BIT);
      check("t2_overflow_pe", n_pe, 1);
      check("t2_value_kept", value, 524287);
      check("t2_rxv", n_rxv, 20);

      send_str("12a4\n");
      send_str("\n");
      send_str("1234567\n"); tick(BIT);
      check("t3_pe", n_pe, 4);
      check("t3_vv", n_vv, 2);
      send_str("7\n"); tick(BIT);
      check("t3_value", value, 7);
      check("t3_rxv", n_rxv, 36);

      send_byte(8'h35, 1'b0); tick(2 * BIT);
      check("t4_fe", n_fe, 1);
      check("t4_rxv", n_rxv, 36);
      check("t4_rx_data_kept", rx_data, 8'h0A);
      send_str("9\n"); tick(BIT);
      check("t4_value", value, 9);
      check("t4_vv", n_vv, 4);

      UART_rx = 1'b0; tick(HALF - 4);
      UART_rx = 1'b1; tick(3 * BIT);
      check("t5_glitch_rxv", n_rxv, 38);
      check("t5_glitch_fe", n_fe, 1);
      send_byte(8'h41, 1'b1);
      send_byte(8'h0A, 1'b1);
      tick(BIT);
      check("t5_b2b_rxv", n_rxv, 40);
      check("t5_b2b_pe", n_pe, 5);

      send_str(" 3\r\n"); tick(BIT);
      check("t5_space_value", value, 3);
      check("t5_space_vv", n_vv, 5);

      send_str("5"); tick(BIT);
      pb = 8'h33;
      UART_rx = 1'b0; tick(BIT);
      for (int i = 0; i < 4; i++) begin
         UART_rx = pb[i]; tick(BIT);
      end
      UART_rx = pb[4]; tick(HALF);
      rst = 1'b1; tick(1);
      rst = 1'b0;
      line_buf.delete();
      @(negedge clk);
      check("t6_rst_rx_data", rx_data, 0);
      check("t6_rst_value", value, 0);
      check("t6_rst_strobes", {rx_valid, frame_err, value_valid, parse_err}, 0);
      tick(2 * BIT);
      send_str("42\n"); tick(BIT);
      check("t6_value", value, 42);
      check("t6_vv", n_vv, 6);
      check("t6_rxv", n_rxv, 48);
      check("t6_pe", n_pe, 5);

      check("end_rx_drained", exp_rx.size(), 0);
      check("end_lines_drained", exp_ok.size(), 0);
      check("end_fe_drained", exp_fe, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
